// File: rtl/i3c_axi_sub_arb.sv
// Burst-locked round-robin arbiter of the write/read component ports onto one CSR port.
// Define I3C_AXI_SUB_ARB_RD_PRIO_EN to give reads fixed priority when both sides contend in IDLE.
module i3c_axi_sub_arb #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int UW        = 32,
    parameter int IW        = 1,
    parameter int TO_CYCLES = 1024,
    parameter int TOW       = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1,
    localparam int BC       = DW / 8
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          w_dv,
    input  logic [AW-1:0] w_addr,
    input  logic [UW-1:0] w_user,
    input  logic [IW-1:0] w_id,
    input  logic [DW-1:0] w_wdata,
    input  logic [BC-1:0] w_wstrb,
    input  logic          w_last,
    output logic          w_hld,
    output logic          w_err,

    input  logic          r_dv,
    input  logic [AW-1:0] r_addr,
    input  logic [UW-1:0] r_user,
    input  logic [IW-1:0] r_id,
    input  logic          r_last,
    output logic          r_hld,
    output logic          r_err,
    output logic [DW-1:0] r_rdata,

    output logic          dv,
    output logic          write,
    output logic [AW-1:0] addr,
    output logic [UW-1:0] user,
    output logic [IW-1:0] id,
    output logic [DW-1:0] wdata,
    output logic [BC-1:0] wstrb,
    input  logic          hld,
    input  logic          err,
    input  logic [DW-1:0] rdata,

    output logic          to_pulse,
    output logic [7:0]    to_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_W = 2'd1,
        OWN_R = 2'd2
    } state_e;

    localparam bit           TO_EN   = (TO_CYCLES != 0);
    localparam logic [TOW-1:0] TO_LAST = TOW'((TO_CYCLES > 0) ? TO_CYCLES - 1 : 0);

    state_e         state_q, state_d;
    logic           last_w_q, last_w_d;
    logic [TOW-1:0] hcnt_q, hcnt_d;
    logic           to_pulse_q, to_pulse_d;
    logic [7:0]     to_cnt_q, to_cnt_d;

    logic sel_w;
    logic sel_r;
    logic sel_dv;
    logic sel_last;
    logic to_fire;
    logic accept;

    // Side selection: free arbitration in IDLE, otherwise the locked owner.
    always_comb begin
        sel_w = 1'b0;
        sel_r = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_dv && r_dv) begin
`ifdef I3C_AXI_SUB_ARB_RD_PRIO_EN
                    sel_r = 1'b1;
`else
                    sel_w = !last_w_q;
                    sel_r = last_w_q;
`endif
                end else if (w_dv) begin
                    sel_w = 1'b1;
                end else if (r_dv) begin
                    sel_r = 1'b1;
                end
            end
            OWN_W:   sel_w = 1'b1;
            OWN_R:   sel_r = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        sel_dv   = 1'b0;
        sel_last = 1'b0;
        if (sel_w) begin
            sel_dv   = w_dv;
            sel_last = w_last;
        end else if (sel_r) begin
            sel_dv   = r_dv;
            sel_last = r_last;
        end
    end

    assign to_fire = TO_EN && (hcnt_q == TO_LAST) && sel_dv && hld;
    assign accept  = sel_dv && (!hld || to_fire);

    // Shared port mux; idle port drives all zeros.
    always_comb begin
        dv    = 1'b0;
        write = 1'b0;
        addr  = '0;
        user  = '0;
        id    = '0;
        wdata = '0;
        wstrb = '0;
        if (sel_w) begin
            dv    = w_dv;
            write = 1'b1;
            addr  = w_addr;
            user  = w_user;
            id    = w_id;
            wdata = w_wdata;
            wstrb = w_wstrb;
        end else if (sel_r) begin
            dv    = r_dv;
            addr  = r_addr;
            user  = r_user;
            id    = r_id;
        end
    end

    // A watchdog expiry completes the beat upstream with an error.
    always_comb begin
        w_hld   = 1'b1;
        w_err   = 1'b0;
        r_hld   = 1'b1;
        r_err   = 1'b0;
        r_rdata = rdata;
        if (sel_w) begin
            w_hld = hld && !to_fire;
            w_err = err || to_fire;
        end
        if (sel_r) begin
            r_hld = hld && !to_fire;
            r_err = err || to_fire;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_w_d   = last_w_q;
        hcnt_d     = hcnt_q;
        to_pulse_d = to_fire;
        to_cnt_d   = to_cnt_q;

        // Tracking every accepted beat equals tracking the finished owner, since the owner is fixed mid-burst.
        if (accept) begin
            last_w_d = sel_w;
        end

        case (state_q)
            IDLE: begin
                if (accept && !sel_last) begin
                    state_d = sel_w ? OWN_W : OWN_R;
                end
            end
            OWN_W, OWN_R: begin
                if (accept && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!TO_EN || !sel_dv || accept) begin
            hcnt_d = '0;
        end else begin
            hcnt_d = hcnt_q + 1'b1;
        end

        if (to_fire && (to_cnt_q != 8'hFF)) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_w_q   <= 1'b0;
            hcnt_q     <= '0;
            to_pulse_q <= 1'b0;
            to_cnt_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            last_w_q   <= last_w_d;
            hcnt_q     <= hcnt_d;
            to_pulse_q <= to_pulse_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign to_pulse = to_pulse_q;
    assign to_cnt   = to_cnt_q;

endmodule

// File: doc/i3c_axi_sub_arb.md
Name: i3c_axi_sub_arb

Overview:
- Arbitrates the write-side and read-side component interfaces of the I3C AXI subordinate onto one shared CSR/register-file access port.
- Grants are burst-locked: once a burst starts, it holds the port until its final beat is accepted. Between bursts the grant alternates round-robin.
- A hold watchdog completes a stuck beat with an error, so one wedged AXI channel cannot deadlock the other.

Parameters:
- AW, 32, byte address width
- DW, 32, data width; BC = DW/8 derived
- UW, 32, user width
- IW, 1, ID width
- TO_CYCLES, 1024, consecutive downstream-hold cycles before forced beat completion; 0 disables the watchdog
- TOW, $clog2(TO_CYCLES+1), watchdog counter width (derived, do not override)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- w_dv  in  1  write beat valid
- w_addr  in  AW  write beat address
- w_user  in  UW  write beat user
- w_id  in  IW  write beat ID
- w_wdata  in  DW  write data
- w_wstrb  in  BC  write byte strobes
- w_last  in  1  final write beat of burst
- w_hld  out  1  stall to write side
- w_err  out  1  error for current write beat
- r_dv  in  1  read beat valid
- r_addr  in  AW  read beat address
- r_user  in  UW  read beat user
- r_id  in  IW  read beat ID
- r_last  in  1  final read beat of burst
- r_hld  out  1  stall to read side
- r_err  out  1  error for current read beat
- r_rdata  out  DW  read data
- dv  out  1  shared port beat valid
- write  out  1  1 = write, 0 = read
- addr  out  AW  shared port address
- user  out  UW  shared port user
- id  out  IW  shared port ID
- wdata  out  DW  shared port write data
- wstrb  out  BC  shared port write strobes
- hld  in  1  downstream stall
- err  in  1  downstream error, valid with dv && !hld
- rdata  in  DW  downstream read data, valid with dv && !hld
- to_pulse  out  1  one-cycle pulse on watchdog expiry
- to_cnt  out  8  saturating count of watchdog expiries

Behaviour:
- State machine: IDLE, OWN_W, OWN_R. Register last_w records the most recent owner (1 = write).
- Selection in IDLE is combinational, so the first beat has zero added latency:
  - only w_dv: select W
  - only r_dv: select R
  - both: select the side not equal to last_w
- Selection outside IDLE: the locked owner.
- Shared port outputs: combinational mux of the selected side. dv = selected side's dv; write = (sel == W). When nothing is selected: dv = 0, write = 0, addr/user/id/wdata/wstrb = 0.
- Non-selected side: its hld is forced to 1 and its err to 0.
- Selected side: hld_side = hld && !to_fire; err_side = err || to_fire.
- r_rdata = rdata at all times. It is qualified by r_dv && !r_hld.
- A beat is accepted when sel_dv && (!hld || to_fire).
- Transitions:
  - IDLE → OWN_x when a beat is accepted without last.
  - IDLE stays IDLE when the accepted beat has last set (single-beat burst); last_w is still updated.
  - OWN_x → IDLE when a beat with last is accepted; last_w is updated to the owner.
- In OWN_x, the owner's dv may drop between beats; the lock is held regardless and the other side keeps hld = 1.
- Watchdog:
  - hcnt increments while sel_dv && hld.
  - hcnt clears on beat acceptance or when sel_dv = 0.
  - to_fire = (TO_CYCLES != 0) && (hcnt == TO_CYCLES-1) && sel_dv && hld.
  - On to_fire: to_pulse = 1 in the next cycle; to_cnt increments and saturates at 255.
  - The downstream keeps seeing dv for that cycle only. It must tolerate an abandoned access.
- Simultaneous events:
  - Final-beat acceptance and a new request from the other side in the same cycle: the other side is granted from the next cycle (IDLE arbitration).
  - No same-cycle back-to-back bursts across owners.
- Reset values: state = IDLE, last_w = 0 (so write wins the first contest), hcnt = 0, to_pulse = 0, to_cnt = 0. All combinational outputs follow from these.
- Reset mid-burst: the lock is dropped immediately. Upstream subordinates are reset by the same rst_n.

Optional Feature:
- Macro: I3C_AXI_SUB_ARB_RD_PRIO_EN.
- Defined: fixed read priority in IDLE. When both sides request, R is selected; last_w is ignored for selection but still updated. The burst lock is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then w_dv and r_dv both 1 with single beats (last = 1), hld = 0 → cycle 0 write = 1, cycle 1 write = 0, cycle 2 write = 1 (alternation); the losing side sees hld = 1 each cycle.
- 4-beat write burst (w_last on beat 4) with r_dv asserted from beat 2 → r_hld = 1 for all 4 write beats; the read is granted in the cycle after beat 4 is accepted.
- Read beat, downstream hld = 1 for 3 cycles, then rdata = 32'hA5A5_0001, err = 1 → r_hld high 3 cycles; r_rdata = A5A5_0001 and r_err = 1 on the accept cycle.
- TO_CYCLES = 8, downstream hld stuck at 1 on a write beat → w_hld drops and w_err = 1 on the 8th hold cycle; to_pulse on the next cycle; to_cnt = 1; a pending read is then granted.
- 300 watchdog expiries → to_cnt = 255 (saturated).
- Assert rst_n = 0 during beat 2 of a 4-beat read burst → next cycle state = IDLE, dv = 0; a first post-reset contest grants write.
